aes_key_sched_seq: RTL and testbench

Sequential, word-serial AES key schedule covering AES-128, AES-192 and AES-256, with the key length selected per run. It generates one 32-bit schedule word per cycle and streams 128-bit round keys 0..Nr over a valid/ready interface. It feeds the iterative cipher datapath and replaces the single-round combinational expansion step used today.

---
 rtl/aes_ks_pkg.sv | 62 ++++++
 rtl/aes_key_sched_seq_if.sv | 36 +++
 rtl/aes_sub_word.sv | 9 +
 rtl/aes_key_sched_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_aes_key_sched_seq.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ks_pkg.sv
// Shared types, constants and byte-level helpers for the word-serial AES key schedule.
package aes_ks_pkg;

    localparam int unsigned WORDS_PER_KEY = 4;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;
    localparam logic [1:0] KL_BAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_EMIT
    } ks_state_e;

    // AES forward S-box, entry 0 is the leftmost byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // multiply by x in GF(2^8); also the Rcon successor
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic int unsigned key_bits_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 192;
            KL_256:  return 256;
            default: return 128;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_sched_seq_if.sv
// Request and round-key stream bundle; AES_KS_REVERSE_EN adds the dec request bit.
interface aes_key_sched_seq_if #(
    parameter int unsigned KEY_MAX_BITS = 256
);
    logic                    start;
    logic [1:0]              key_len;
    logic [0:KEY_MAX_BITS-1] key_in;
    logic                    abort;
`ifdef AES_KS_REVERSE_EN
    logic                    dec;
`endif
    logic                    busy;
    logic                    err;
    logic                    rk_valid;
    logic                    rk_ready;
    logic [0:127]            rk_data;
    logic [3:0]              rk_idx;
    logic                    rk_last;
    logic                    done;

    modport master (
        output start, key_len, key_in, abort, rk_ready,
`ifdef AES_KS_REVERSE_EN
        output dec,
`endif
        input  busy, err, rk_valid, rk_data, rk_idx, rk_last, done
    );

    modport slave (
        input  start, key_len, key_in, abort, rk_ready,
`ifdef AES_KS_REVERSE_EN
        input  dec,
`endif
        output busy, err, rk_valid, rk_data, rk_idx, rk_last, done
    );
endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four S-box lookups across a 32-bit word.
module aes_sub_word
    import aes_ks_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] sub_o
);
    assign sub_o = {sbox(word_i[31:24]), sbox(word_i[23:16]), sbox(word_i[15:8]), sbox(word_i[7:0])};
endmodule

// File: rtl/aes_key_sched_seq.sv
// Word-serial AES-128/192/256 key schedule streaming 128-bit round keys.
// Optional macro AES_KS_REVERSE_EN: store all words and emit keys Nr..0 when dec=1.
module aes_key_sched_seq
    import aes_ks_pkg::*;
#(
    parameter int unsigned KEY_MAX_BITS = 256,
    parameter int unsigned OUT_SKID     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_sched_seq_if.slave   bus
);
    localparam int unsigned WIN_WORDS = 8;
    localparam int unsigned GRP_WORDS = WORDS_PER_KEY - 1;

    ks_state_e    state_q, state_d;
    logic [0:255] key_q, key_d;
    logic [1:0]   kl_q, kl_d;
    logic [5:0]   j_q, j_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  win_q [0:WIN_WORDS-1];
    logic [31:0]  win_d [0:WIN_WORDS-1];
    logic [31:0]  grp_q [0:GRP_WORDS-1];
    logic [31:0]  grp_d [0:GRP_WORDS-1];
    logic         busy_q, busy_d, err_q, err_d, done_q, done_d;
    logic         vld_q, vld_d, last_q, last_d;
    logic [0:127] data_q, data_d;
    logic [3:0]   idx_q, idx_d;

    logic [31:0]  key_w_c [0:WIN_WORDS-1];
    logic [3:0]   nk_c, nr_c;
    logic [5:0]   total_c;
    logic [31:0]  prev_c, far_c, sub_in_c, sub_c, w_new_c;
    logic         legal_c, xfer_c, grp_end_c, stall_c, gen_go_c, key_phase_c;

`ifdef AES_KS_REVERSE_EN
    logic         dec_q, dec_d, rd_pend_q, rd_pend_d, store_we_c;
    logic [3:0]   rdk_q, rdk_d;
    logic [5:0]   rd_base_c;
    logic [31:0]  store_q [0:59];
`endif

    aes_sub_word u_sub_word (
        .word_i (sub_in_c),
        .sub_o  (sub_c)
    );

    // next schedule word from the sliding window; one SubWord serves both t cases
    always_comb begin
        for (int i = 0; i < int'(WIN_WORDS); i++) key_w_c[i] = key_q[32*i +: 32];
        nk_c        = nk_of(kl_q);
        nr_c        = nr_of(kl_q);
        total_c     = {nr_c, 2'b00} + 6'd4;
        prev_c      = win_q[0];
        far_c       = win_q[3'(nk_c - 4'd1)];
        key_phase_c = (j_q < 6'(nk_c));
        sub_in_c    = (cnt_q == 3'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;
        if (key_phase_c)
            w_new_c = key_w_c[cnt_q];
        else if (cnt_q == 3'd0)
            w_new_c = far_c ^ sub_c ^ {rcon_q, 24'h0};
        else if (nk_c == 4'd8 && cnt_q == 3'd4)
            w_new_c = far_c ^ sub_c;
        else
            w_new_c = far_c ^ prev_c;
    end

    // handshake, stall and request legality
    always_comb begin
        legal_c   = (bus.key_len != KL_BAD) && (key_bits_of(bus.key_len) <= KEY_MAX_BITS);
        xfer_c    = vld_q && bus.rk_ready;
        grp_end_c = (j_q[1:0] == 2'(WORDS_PER_KEY - 1));
        stall_c   = vld_q && !bus.rk_ready && ((OUT_SKID == 0) || grp_end_c);
        gen_go_c  = (state_q == ST_GEN) && (j_q < total_c) && !stall_c;
    end

    // next-state and output-register logic
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        kl_d    = kl_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        win_d   = win_q;
        grp_d   = grp_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        vld_d   = vld_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef AES_KS_REVERSE_EN
        dec_d      = dec_q;
        rd_pend_d  = rd_pend_q;
        rdk_d      = rdk_q;
        store_we_c = 1'b0;
        rd_base_c  = {rdk_q, 2'b00};
`endif
        if (bus.abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (legal_c) begin
                            key_d = '0;
                            key_d[0 +: KEY_MAX_BITS] = bus.key_in;
                            kl_d    = bus.key_len;
                            j_d     = 6'd0;
                            cnt_d   = 3'd0;
                            rcon_d  = 8'h01;
                            busy_d  = 1'b1;
                            err_d   = 1'b0;
                            state_d = ST_GEN;
`ifdef AES_KS_REVERSE_EN
                            dec_d   = bus.dec;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_GEN: begin
                    if (xfer_c) vld_d = 1'b0;
                    if (xfer_c && last_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (gen_go_c) begin
                        win_d[0] = w_new_c;
                        for (int i = 1; i < int'(WIN_WORDS); i++) win_d[i] = win_q[i-1];
                        j_d   = j_q + 6'd1;
                        cnt_d = (cnt_q == 3'(nk_c - 4'd1)) ? 3'd0 : cnt_q + 3'd1;
                        if (!key_phase_c && cnt_q == 3'd0) rcon_d = xtime(rcon_q);
`ifdef AES_KS_REVERSE_EN
                        if (dec_q) begin
                            store_we_c = 1'b1;
                            if (j_q == total_c - 6'd1) begin
                                state_d   = ST_EMIT;
                                rd_pend_d = 1'b1;
                                rdk_d     = nr_c;
                            end
                        end else
`endif
                        if (grp_end_c) begin
                            vld_d  = 1'b1;
                            data_d = {grp_q[0], grp_q[1], grp_q[2], w_new_c};
                            idx_d  = j_q[5:2];
                            last_d = (j_q[5:2] == nr_c);
                        end else begin
                            for (int i = 0; i < int'(GRP_WORDS); i++)
                                if (j_q[1:0] == 2'(i)) grp_d[i] = w_new_c;
                        end
                    end
                end
`ifdef AES_KS_REVERSE_EN
                ST_EMIT: begin
                    if (xfer_c) vld_d = 1'b0;
                    if (xfer_c && last_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (rd_pend_q && (!vld_q || bus.rk_ready)) begin
                        vld_d  = 1'b1;
                        data_d = {store_q[rd_base_c], store_q[rd_base_c + 6'd1],
                                  store_q[rd_base_c + 6'd2], store_q[rd_base_c + 6'd3]};
                        idx_d  = rdk_q;
                        last_d = (rdk_q == 4'd0);
                        if (rdk_q == 4'd0) rd_pend_d = 1'b0;
                        else               rdk_d     = rdk_q - 4'd1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            kl_q    <= KL_128;
            j_q     <= '0;
            cnt_q   <= '0;
            rcon_q  <= '0;
            for (int i = 0; i < int'(WIN_WORDS); i++) win_q[i] <= '0;
            for (int i = 0; i < int'(GRP_WORDS); i++) grp_q[i] <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
`ifdef AES_KS_REVERSE_EN
            dec_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rdk_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            kl_q    <= kl_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            win_q   <= win_d;
            grp_q   <= grp_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef AES_KS_REVERSE_EN
            dec_q     <= dec_d;
            rd_pend_q <= rd_pend_d;
            rdk_q     <= rdk_d;
`endif
        end
    end

`ifdef AES_KS_REVERSE_EN
    // full-schedule word store for reverse emission
    always_ff @(posedge clk) begin
        if (store_we_c) store_q[j_q] <= w_new_c;
    end
`endif

    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.done     = done_q;
    assign bus.rk_valid = vld_q;
    assign bus.rk_data  = data_q;
    assign bus.rk_idx   = idx_q;
    assign bus.rk_last  = last_q;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Scoreboard bench for aes_key_sched_seq using FIPS-197 expansion vectors.
module tb_aes_key_sched_seq;

    logic clk = 1'b0;
    logic rst_n;

    aes_key_sched_seq_if #(.KEY_MAX_BITS(256)) bus ();

    aes_key_sched_seq #(.KEY_MAX_BITS(256), .OUT_SKID(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic         last;
        logic         chk;
        logic [127:0] data;
    } exp_t;

    exp_t sb [$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;

    logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] E128 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // queue expected keys 0..upto (upto<0 means the whole schedule)
    task automatic push_run(input logic [1:0] kl, input int upto);
        int nr;
        exp_t e;
        nr = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
        if (upto < 0) upto = nr;
        for (int k = 0; k <= upto; k++) begin
            e.idx = 4'(k); e.last = (k == nr); e.chk = 1'b0; e.data = '0;
            case (kl)
                2'b00: begin e.chk = 1'b1; e.data = E128[k]; end
                2'b01: begin
                    if (k == 0)  begin e.chk = 1'b1; e.data = 128'h8e73b0f7da0e6452c810f32b809079e5; end
                    if (k == 12) begin e.chk = 1'b1; e.data = 128'he98ba06f448c773c8ecc720401002202; end
                end
                default: begin
                    if (k == 0)  begin e.chk = 1'b1; e.data = 128'h603deb1015ca71be2b73aef0857d7781; end
                    if (k == 1)  begin e.chk = 1'b1; e.data = 128'h1f352c073b6108d72d9810a30914dff4; end
                    if (k == 14) begin e.chk = 1'b1; e.data = 128'hfe4890d1e6188d0b046df344706c631e; end
                end
            endcase
            sb.push_back(e);
        end
    endtask

    // one-cycle start pulse; returns just after the accepting edge
    task automatic do_start(input logic [1:0] kl, input logic [0:255] key);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.key_len = kl; bus.key_in = key;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            n++;
        end
        chk({name, "_done"}, 128'(seen), 128'd1);
        chk({name, "_busy_after"}, 128'(bus.busy), 128'd0);
        chk({name, "_sb_empty"}, 128'(sb.size()), 128'd0);
    endtask

    task automatic wait_key(input string name, input logic [3:0] idx, input int budget);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (bus.rk_valid && bus.rk_idx == idx) seen = 1'b1;
            n++;
        end
        chk({name, "_key_seen"}, 128'(seen), 128'd1);
    endtask

    // monitor: pops the scoreboard on each transfer and checks hold stability
    initial begin : monitor
        logic         hold;
        logic [127:0] pd;
        logic [3:0]   pi;
        logic         pl;
        exp_t         e;
        hold = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 128'(bus.rk_valid), 128'd1);
                    chk("hold_data", bus.rk_data, pd);
                    chk("hold_idx", 128'(bus.rk_idx), 128'(pi));
                    chk("hold_last", 128'(bus.rk_last), 128'(pl));
                end
                if (bus.rk_valid && bus.rk_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_key: idx %0d transferred, nothing queued", bus.rk_idx);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("key%0d_idx", e.idx), 128'(bus.rk_idx), 128'(e.idx));
                        chk($sformatf("key%0d_last", e.idx), 128'(bus.rk_last), 128'(e.last));
                        if (e.chk) chk($sformatf("key%0d_data", e.idx), bus.rk_data, e.data);
                    end
                end
                if (bus.done) done_cnt++;
                hold = bus.rk_valid && !bus.rk_ready && !bus.abort;
                pd = bus.rk_data; pi = bus.rk_idx; pl = bus.rk_last;
            end
        end
    end

    initial begin : stim
        int d0;
        bit seen;
        bus.start = 1'b0; bus.key_len = 2'b00; bus.key_in = '0; bus.abort = 1'b0; bus.rk_ready = 1'b1;
`ifdef AES_KS_REVERSE_EN
        bus.dec = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_err", 128'(bus.err), 128'd0);
        chk("rst_valid", 128'(bus.rk_valid), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_idx", 128'(bus.rk_idx), 128'd0);
        chk("rst_last", 128'(bus.rk_last), 128'd0);
        chk("rst_data", bus.rk_data, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // AES-128 with latency check
        push_run(2'b00, -1);
        do_start(2'b00, K128);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lat_valid_t3", 128'(bus.rk_valid), 128'd0);
        chk("lat_busy", 128'(bus.busy), 128'd1);
        @(posedge clk); @(negedge clk);
        chk("lat_valid_t4", 128'(bus.rk_valid), 128'd1);
        wait_done("aes128", 200);

        // AES-192 and AES-256
        push_run(2'b01, -1);
        do_start(2'b01, K192);
        wait_done("aes192", 200);
        push_run(2'b10, -1);
        do_start(2'b10, K256);
        wait_done("aes256", 200);

        // backpressure: hold k0 for 20 cycles, then random ready
        bus.rk_ready = 1'b0;
        push_run(2'b00, -1);
        do_start(2'b00, K128);
        wait_key("bp", 4'd0, 20);
        repeat (20) begin
            @(negedge clk);
            chk("bp_k0_valid", 128'(bus.rk_valid), 128'd1);
            chk("bp_k0_data", bus.rk_data, E128[0]);
        end
        seen = 1'b0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
            bus.rk_ready = 1'($urandom_range(0, 1));
        end
        chk("bp_done", 128'(seen), 128'd1);
        chk("bp_sb_empty", 128'(sb.size()), 128'd0);
        bus.rk_ready = 1'b1;

        // abort while k3 of AES-256 is held
        push_run(2'b10, 2);
        do_start(2'b10, K256);
        wait_key("ab2", 4'd2, 40);
        @(posedge clk); #1 bus.rk_ready = 1'b0;
        wait_key("ab3", 4'd3, 40);
        d0 = done_cnt;
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 128'(bus.rk_valid), 128'd0);
        chk("abort_busy", 128'(bus.busy), 128'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt), 128'(d0));
        chk("abort_sb_empty", 128'(sb.size()), 128'd0);
        bus.rk_ready = 1'b1;

        // AES-128 after abort, with an ignored start mid-run
        push_run(2'b00, -1);
        do_start(2'b00, K128);
        repeat (5) @(posedge clk);
        do_start(2'b10, K256);
        wait_done("post_abort", 200);

        // abort and start together: abort wins
        @(posedge clk); #1 bus.start = 1'b1; bus.abort = 1'b1; bus.key_len = 2'b00; bus.key_in = K128;
        @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("abst_busy", 128'(bus.busy), 128'd0);
        repeat (6) @(negedge clk);
        chk("abst_valid", 128'(bus.rk_valid), 128'd0);

        // illegal key_len, then a legal start clears err
        do_start(2'b11, K128);
        @(negedge clk);
        chk("ill_err", 128'(bus.err), 128'd1);
        chk("ill_busy", 128'(bus.busy), 128'd0);
        repeat (8) @(negedge clk);
        chk("ill_valid", 128'(bus.rk_valid), 128'd0);
        chk("ill_err_sticky", 128'(bus.err), 128'd1);
        push_run(2'b00, -1);
        do_start(2'b00, K128);
        @(negedge clk);
        chk("ill_err_clr", 128'(bus.err), 128'd0);
        wait_done("after_ill", 200);

        // asynchronous reset mid-run
        bus.rk_ready = 1'b0;
        do_start(2'b01, K192);
        wait_key("rst_mid", 4'd0, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 128'(bus.rk_valid), 128'd0);
        chk("rstmid_busy", 128'(bus.busy), 128'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.rk_ready = 1'b1;
        push_run(2'b00, -1);
        do_start(2'b00, K128);
        wait_done("after_rst", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
